seq_mul: RTL

Parametrised sequential shift-add multiplier: takes two WIDTH-bit operands on a start pulse and produces the 2*WIDTH-bit product after a fixed WIDTH-cycle iteration. It is the area-lean successor to the combinational 2-bit array multiplier. It suits datapaths where one product per WIDTH+1 cycles is acceptable. Each iteration uses one WIDTH-bit adder instead of an adder array.

---
 rtl/seq_mul_pkg.sv | 17 +
 rtl/seq_mul_add.sv | 37 +++
 rtl/seq_mul.sv | 95 +++++++++
 3 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the seq_mul shift-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;

  // Iteration counter width; must hold values 0..WIDTH-1.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_mul_add.sv
// Ripple add/subtract of multiplicand x and upper accumulator half y.
// Result is WIDTH+1 bits so the carry (unsigned) or sign (signed) is kept.
// SEQ_MUL_SIGNED_EN: operands are sign-extended instead of zero-extended.
module seq_mul_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH:0]   s
);

  logic [WIDTH:0] xe, ye, xo, c;

`ifdef SEQ_MUL_SIGNED_EN
  assign xe = {x[WIDTH-1], x};
  assign ye = {y[WIDTH-1], y};
`else
  assign xe = {1'b0, x};
  assign ye = {1'b0, y};
`endif

  // Subtraction as y + ~x + 1: invert x, inject the +1 as carry-in.
  assign xo   = xe ^ {(WIDTH+1){sub}};
  assign c[0] = sub;

  genvar i;
  generate
    for (i = 0; i <= WIDTH; i++) begin : g_bit
      assign s[i] = xo[i] ^ ye[i] ^ c[i];
      if (i < WIDTH) begin : g_cy
        assign c[i+1] = (xo[i] & ye[i]) | (c[i] & (xo[i] ^ ye[i]));
      end
    end
  endgenerate

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: WIDTH RUN cycles per product, one
// DONE cycle, result in p. SEQ_MUL_SIGNED_EN selects two's-complement
// operands (arithmetic shift, subtract on the multiplier sign bit).
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int             CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH-1);

  state_t             state, nxt;
  logic               take;
  logic               last;
  logic               sub;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mx;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH:0]     sum;

  assign last = (state == RUN) && (cnt == CNT_LAST);
  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef SEQ_MUL_SIGNED_EN
  // Multiplier sign bit has weight -2^(WIDTH-1): subtract on the final step.
  assign sub = last & acc[0];
`else
  assign sub = 1'b0;
`endif

  // Add the multiplicand only when the current multiplier bit is set.
  assign mx = acc[0] ? mcand : '0;

  seq_mul_add #(.WIDTH(WIDTH)) u_add (
    .x  (mx),
    .y  (acc[2*WIDTH-1:WIDTH]),
    .sub(sub),
    .s  (sum)
  );

  // Shift {carry/sign, acc} right by one; the WIDTH+1-bit sum drops in on top.
  assign acc_nxt = {sum, acc[WIDTH-1:1]};

  // Next-state: start accepted only in IDLE or DONE.
  always_comb begin
    nxt  = state;
    take = 1'b0;
    case (state)
      IDLE: if (start) begin nxt = RUN; take = 1'b1; end
      RUN:  if (cnt == CNT_LAST) nxt = DONE;
      DONE: begin
        if (start) begin nxt = RUN; take = 1'b1; end
        else       nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Datapath: operand capture, iteration, result publish on DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
      p     <= '0;
    end else if (take) begin
      cnt   <= '0;
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      acc <= acc_nxt;
      if (last) p <= acc_nxt;
    end
  end

endmodule
